// File: rtl/stage_phase_monitor.sv
// Receiving side of the stage/phase code: tracks the 2-bit phase, checks order and
// per-phase duration, locks onto the sequence and drives registered one-hot enables.
module stage_phase_monitor #(
  parameter int unsigned LEN_W = 9,
  parameter int unsigned MIN0  = 96,
  parameter int unsigned MAX0  = 106,
  parameter int unsigned MIN1  = 18,
  parameter int unsigned MAX1  = 22,
  parameter int unsigned MIN2  = 76,
  parameter int unsigned MAX2  = 84
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       phase_in,
  input  logic             clr_err,
  output logic             en_p0,
  output logic             en_p1,
  output logic             en_p2,
  output logic             locked,
  output logic [LEN_W-1:0] last_len,
  output logic [7:0]       round_cnt,
  output logic             err_order,
  output logic             err_len,
  output logic             err_code
);

  localparam logic [LEN_W-1:0] Min0L = LEN_W'(MIN0);
  localparam logic [LEN_W-1:0] Max0L = LEN_W'(MAX0);
  localparam logic [LEN_W-1:0] Min1L = LEN_W'(MIN1);
  localparam logic [LEN_W-1:0] Max1L = LEN_W'(MAX1);
  localparam logic [LEN_W-1:0] Min2L = LEN_W'(MIN2);
  localparam logic [LEN_W-1:0] Max2L = LEN_W'(MAX2);

  typedef enum logic [1:0] {StUnsync, StSync, StLocked} state_e;

  state_e           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic [LEN_W-1:0] len_cnt_q, len_cnt_d;
  logic [LEN_W-1:0] last_len_q, last_len_d;
  logic [7:0]       round_cnt_q, round_cnt_d;
  logic [2:0]       en_q, en_d;
  logic             locked_q, locked_d;
  logic             err_order_q, err_order_d;
  logic             err_len_q, err_len_d;
  logic             err_code_q, err_code_d;

  logic             change, legal, wrap, checking;
  logic             ev_order, ev_len, ev_code;
  logic [LEN_W-1:0] len_lo, len_hi;

  // Transition decode, error events, next state and next outputs.
  always_comb begin
    change   = (phase_in != phase_q);
    legal    = change && (((phase_q == 2'b00) && (phase_in == 2'b01)) ||
                          ((phase_q == 2'b01) && (phase_in == 2'b10)) ||
                          ((phase_q == 2'b10) && (phase_in == 2'b00)));
    wrap     = change && (phase_q == 2'b10) && (phase_in == 2'b00);
    checking = (state_q != StUnsync);

    len_lo = '0;
    len_hi = '1;
    case (phase_q)
      2'b00:   begin len_lo = Min0L; len_hi = Max0L; end
      2'b01:   begin len_lo = Min1L; len_hi = Max1L; end
      2'b10:   begin len_lo = Min2L; len_hi = Max2L; end
      default: begin len_lo = '0;    len_hi = '1;    end
    endcase

    // Length is judged against the phase being left, only on legal changes.
    ev_code  = (phase_in == 2'b11);
    ev_order = checking && change && !legal;
    ev_len   = checking && legal && ((len_cnt_q < len_lo) || (len_cnt_q > len_hi));

    state_d = state_q;
    if (ev_code || ev_order || ev_len) begin
      state_d = StUnsync;
    end else if (wrap) begin
      case (state_q)
        StUnsync: state_d = StSync;
        StSync:   state_d = StLocked;
        default:  state_d = StLocked;
      endcase
    end

    phase_d     = phase_in;
    len_cnt_d   = change ? LEN_W'(1) : ((len_cnt_q == '1) ? len_cnt_q : len_cnt_q + LEN_W'(1));
    last_len_d  = (checking && change) ? len_cnt_q : last_len_q;
    round_cnt_d = round_cnt_q;
    if ((state_q == StLocked) && (state_d == StLocked) && wrap) begin
      round_cnt_d = round_cnt_q + 8'd1;
    end

    // Error event wins over a simultaneous clear.
    err_order_d = ev_order | (err_order_q & ~clr_err);
    err_len_d   = ev_len   | (err_len_q   & ~clr_err);
    err_code_d  = ev_code  | (err_code_q  & ~clr_err);

    en_d = 3'b000;
    if (state_d == StLocked) begin
      case (phase_in)
        2'b00:   en_d = 3'b001;
        2'b01:   en_d = 3'b010;
        2'b10:   en_d = 3'b100;
        default: en_d = 3'b000;
      endcase
    end
    locked_d = (state_d == StLocked);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StUnsync;
      phase_q     <= 2'b00;
      len_cnt_q   <= LEN_W'(1);
      last_len_q  <= '0;
      round_cnt_q <= 8'd0;
      en_q        <= 3'b000;
      locked_q    <= 1'b0;
      err_order_q <= 1'b0;
      err_len_q   <= 1'b0;
      err_code_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      len_cnt_q   <= len_cnt_d;
      last_len_q  <= last_len_d;
      round_cnt_q <= round_cnt_d;
      en_q        <= en_d;
      locked_q    <= locked_d;
      err_order_q <= err_order_d;
      err_len_q   <= err_len_d;
      err_code_q  <= err_code_d;
    end
  end

  assign en_p0     = en_q[0];
  assign en_p1     = en_q[1];
  assign en_p2     = en_q[2];
  assign locked    = locked_q;
  assign last_len  = last_len_q;
  assign round_cnt = round_cnt_q;
  assign err_order = err_order_q;
  assign err_len   = err_len_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_stage_phase_monitor.sv
// Directed bench for stage_phase_monitor: inputs change on the falling edge,
// outputs are sampled on the falling edge after the rising edge that consumed them.
module tb_stage_phase_monitor;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [1:0] phase_in = 2'b00;
  logic       clr_err = 1'b0;
  logic       en_p0, en_p1, en_p2, locked;
  logic [8:0] last_len;
  logic [7:0] round_cnt;
  logic       err_order, err_len, err_code;
  int         n_chk = 0;
  int         n_fail = 0;

  stage_phase_monitor dut (
    .clk(clk), .rst(rst), .phase_in(phase_in), .clr_err(clr_err),
    .en_p0(en_p0), .en_p1(en_p1), .en_p2(en_p2), .locked(locked),
    .last_len(last_len), .round_cnt(round_cnt),
    .err_order(err_order), .err_len(err_len), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic drive(input logic [1:0] code, input int n);
    phase_in = code;
    repeat (n) @(negedge clk);
  endtask

  // From any UNSYNC point: a 10->00 wrap to SYNC, then a clean round to LOCKED.
  task automatic sync_up();
    drive(2'b10, 80); drive(2'b00, 101); drive(2'b01, 20); drive(2'b10, 80); drive(2'b00, 1);
  endtask

  task automatic test_reset();
    rst = 1'b0; phase_in = 2'b00; clr_err = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    n_chk++; if ({en_p2, en_p1, en_p0} !== 3'b000) begin n_fail++; $display("FAIL reset_en: got %b want 000", {en_p2, en_p1, en_p0}); end
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked); end
    n_chk++; if (last_len !== 9'd0) begin n_fail++; $display("FAIL reset_last_len: got %0d want 0", last_len); end
    n_chk++; if (round_cnt !== 8'd0) begin n_fail++; $display("FAIL reset_round_cnt: got %0d want 0", round_cnt); end
    n_chk++; if ({err_order, err_len, err_code} !== 3'b000) begin n_fail++; $display("FAIL reset_err: got %b want 000", {err_order, err_len, err_code}); end
  endtask

  task automatic test_clean_rounds();
    drive(2'b00, 101); drive(2'b01, 20); drive(2'b10, 80);
    drive(2'b00, 1);
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL sync_locked: got %b want 0", locked); end
    n_chk++; if ({en_p2, en_p1, en_p0} !== 3'b000) begin n_fail++; $display("FAIL sync_en: got %b want 000", {en_p2, en_p1, en_p0}); end
    drive(2'b00, 100); drive(2'b01, 20); drive(2'b10, 80);
    drive(2'b00, 1);
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL lock_locked: got %b want 1", locked); end
    n_chk++; if ({en_p2, en_p1, en_p0} !== 3'b001) begin n_fail++; $display("FAIL lock_en0: got %b want 001", {en_p2, en_p1, en_p0}); end
    n_chk++; if (last_len !== 9'd80) begin n_fail++; $display("FAIL lock_last_len: got %0d want 80", last_len); end
    n_chk++; if (round_cnt !== 8'd0) begin n_fail++; $display("FAIL lock_round_cnt: got %0d want 0", round_cnt); end
    drive(2'b00, 100);
    phase_in = 2'b01; #1;
    n_chk++; if ({en_p2, en_p1, en_p0} !== 3'b001) begin n_fail++; $display("FAIL latency_pre: got %b want 001", {en_p2, en_p1, en_p0}); end
    @(negedge clk);
    n_chk++; if ({en_p2, en_p1, en_p0} !== 3'b010) begin n_fail++; $display("FAIL en1: got %b want 010", {en_p2, en_p1, en_p0}); end
    n_chk++; if (last_len !== 9'd101) begin n_fail++; $display("FAIL last_len_p0: got %0d want 101", last_len); end
    drive(2'b01, 19); drive(2'b10, 1);
    n_chk++; if ({en_p2, en_p1, en_p0} !== 3'b100) begin n_fail++; $display("FAIL en2: got %b want 100", {en_p2, en_p1, en_p0}); end
    n_chk++; if (last_len !== 9'd20) begin n_fail++; $display("FAIL last_len_p1: got %0d want 20", last_len); end
    drive(2'b10, 79); drive(2'b00, 1);
    n_chk++; if (round_cnt !== 8'd1) begin n_fail++; $display("FAIL round1: got %0d want 1", round_cnt); end
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL round1_locked: got %b want 1", locked); end
    n_chk++; if ({err_order, err_len, err_code} !== 3'b000) begin n_fail++; $display("FAIL clean_err: got %b want 000", {err_order, err_len, err_code}); end
  endtask

  task automatic test_len_err();
    drive(2'b00, 100); drive(2'b01, 25); drive(2'b10, 1);
    n_chk++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL len_err: got %b want 1", err_len); end
    n_chk++; if (last_len !== 9'd25) begin n_fail++; $display("FAIL len_last_len: got %0d want 25", last_len); end
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL len_locked: got %b want 0", locked); end
    n_chk++; if ({en_p2, en_p1, en_p0} !== 3'b000) begin n_fail++; $display("FAIL len_en: got %b want 000", {en_p2, en_p1, en_p0}); end
    n_chk++; if (err_order !== 1'b0) begin n_fail++; $display("FAIL len_no_order: got %b want 0", err_order); end
    sync_up();
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL len_relock: got %b want 1", locked); end
    clr_err = 1'b1; drive(2'b00, 1); clr_err = 1'b0;
    n_chk++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL len_clr: got %b want 0", err_len); end
  endtask

  task automatic test_order_err();
    drive(2'b00, 99); drive(2'b10, 1);
    n_chk++; if (err_order !== 1'b1) begin n_fail++; $display("FAIL order_err: got %b want 1", err_order); end
    n_chk++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL order_no_len: got %b want 0", err_len); end
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL order_locked: got %b want 0", locked); end
    sync_up();
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL order_relock: got %b want 1", locked); end
    n_chk++; if (err_order !== 1'b1) begin n_fail++; $display("FAIL order_sticky: got %b want 1", err_order); end
    clr_err = 1'b1; drive(2'b00, 1); clr_err = 1'b0;
    n_chk++; if (err_order !== 1'b0) begin n_fail++; $display("FAIL order_clr: got %b want 0", err_order); end
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL order_clr_locked: got %b want 1", locked); end
  endtask

  task automatic test_code_err();
    drive(2'b00, 48); drive(2'b11, 1);
    n_chk++; if (err_code !== 1'b1) begin n_fail++; $display("FAIL code_err: got %b want 1", err_code); end
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL code_locked: got %b want 0", locked); end
    n_chk++; if ({en_p2, en_p1, en_p0} !== 3'b000) begin n_fail++; $display("FAIL code_en: got %b want 000", {en_p2, en_p1, en_p0}); end
    drive(2'b00, 5);
    clr_err = 1'b1; drive(2'b00, 1); clr_err = 1'b0;
    n_chk++; if ({err_order, err_len, err_code} !== 3'b000) begin n_fail++; $display("FAIL code_clr: got %b want 000", {err_order, err_len, err_code}); end
    // Code 11 while unsynchronised is still flagged.
    drive(2'b11, 1);
    n_chk++; if (err_code !== 1'b1) begin n_fail++; $display("FAIL code_unsync: got %b want 1", err_code); end
    clr_err = 1'b1; drive(2'b00, 1); clr_err = 1'b0;
  endtask

  task automatic test_clr_same_cycle();
    sync_up();
    drive(2'b00, 100); drive(2'b01, 25);
    clr_err = 1'b1; drive(2'b10, 1); clr_err = 1'b0;
    n_chk++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL clr_race_set: got %b want 1", err_len); end
    clr_err = 1'b1; drive(2'b10, 1); clr_err = 1'b0;
    n_chk++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL clr_race_clear: got %b want 0", err_len); end
  endtask

  task automatic test_bounds();
    sync_up();
    drive(2'b00, 95); drive(2'b01, 22); drive(2'b10, 84); drive(2'b00, 1);
    n_chk++; if (round_cnt !== 8'd2) begin n_fail++; $display("FAIL bounds_lo_hi: round_cnt %0d want 2", round_cnt); end
    drive(2'b00, 105); drive(2'b01, 18); drive(2'b10, 76); drive(2'b00, 1);
    n_chk++; if (round_cnt !== 8'd3) begin n_fail++; $display("FAIL bounds_hi_lo: round_cnt %0d want 3", round_cnt); end
    n_chk++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL bounds_no_err: got %b want 0", err_len); end
    drive(2'b00, 94); drive(2'b01, 1);
    n_chk++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL bounds_short: got %b want 1", err_len); end
    n_chk++; if (last_len !== 9'd95) begin n_fail++; $display("FAIL bounds_short_len: got %0d want 95", last_len); end
    clr_err = 1'b1; drive(2'b01, 1); clr_err = 1'b0;
  endtask

  task automatic test_saturation();
    sync_up();
    drive(2'b00, 549);
    n_chk++; if (err_len !== 1'b0) begin n_fail++; $display("FAIL sat_held: err_len %b want 0", err_len); end
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL sat_held_locked: got %b want 1", locked); end
    drive(2'b00, 50); drive(2'b01, 1);
    n_chk++; if (err_len !== 1'b1) begin n_fail++; $display("FAIL sat_err: got %b want 1", err_len); end
    n_chk++; if (last_len !== 9'd511) begin n_fail++; $display("FAIL sat_len: got %0d want 511", last_len); end
    clr_err = 1'b1; drive(2'b01, 1); clr_err = 1'b0;
  endtask

  task automatic test_reset_mid();
    sync_up();
    n_chk++; if (round_cnt !== 8'd3) begin n_fail++; $display("FAIL pre_reset_round: got %0d want 3", round_cnt); end
    drive(2'b00, 100); drive(2'b01, 20); drive(2'b10, 40);
    rst = 1'b0; drive(2'b10, 1); rst = 1'b1;
    n_chk++; if ({en_p2, en_p1, en_p0, locked} !== 4'b0000) begin n_fail++; $display("FAIL mid_reset_en_lock: got %b want 0000", {en_p2, en_p1, en_p0, locked}); end
    n_chk++; if (round_cnt !== 8'd0) begin n_fail++; $display("FAIL mid_reset_round: got %0d want 0", round_cnt); end
    n_chk++; if (last_len !== 9'd0) begin n_fail++; $display("FAIL mid_reset_last_len: got %0d want 0", last_len); end
    drive(2'b10, 40); drive(2'b00, 1);
    n_chk++; if (locked !== 1'b0) begin n_fail++; $display("FAIL mid_reset_unsync: locked %b want 0", locked); end
    drive(2'b00, 100); drive(2'b01, 20); drive(2'b10, 80); drive(2'b00, 1);
    n_chk++; if (locked !== 1'b1) begin n_fail++; $display("FAIL post_reset_lock: got %b want 1", locked); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_clean_rounds();
    test_len_err();
    test_order_err();
    test_code_err();
    test_clr_same_cycle();
    test_bounds();
    test_saturation();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/stage_phase_monitor.md
Name: stage_phase_monitor

Overview:
- Receiving end of the 2-bit stage/phase code produced by the stage controller: 00 = phase 0 (red/IF-ID), 01 = phase 1 (amber), 10 = phase 2 (green).
- Tracks the incoming code, checks transition order and per-phase duration, and locks onto the sequence.
- Once locked, drives registered one-hot stage enables to the datapath.
- Flags sticky protocol errors for the control/debug logic and counts completed rounds.

Parameters:
LEN_W, 9, width of run-length counter and last_len
MIN0, 96, minimum legal phase-0 length (cycles)
MAX0, 106, maximum legal phase-0 length
MIN1, 18, minimum legal phase-1 length
MAX1, 22, maximum legal phase-1 length
MIN2, 76, minimum legal phase-2 length
MAX2, 84, maximum legal phase-2 length

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  reset, synchronous, active-low (rst==0 at a rising edge resets)
phase_in  in  2  phase code from stage controller, synchronous to clk
clr_err  in  1  clears sticky error flags
en_p0  out  1  stage-0 enable, registered
en_p1  out  1  stage-1 enable, registered
en_p2  out  1  stage-2 enable, registered
locked  out  1  high while FSM is in LOCKED
last_len  out  LEN_W  length of most recently completed phase
round_cnt  out  8  completed rounds while locked, wraps 255->0
err_order  out  1  sticky: illegal transition seen
err_len  out  1  sticky: phase length outside [MINx,MAXx]
err_code  out  1  sticky: code 11 seen

Behaviour:
- Reset (rst==0 at edge): FSM=UNSYNC, phase_q=00, len_cnt=1. All outputs 0; last_len=0, round_cnt=0.
- phase_q: registered copy of phase_in.
- change = (phase_in != phase_q). This is a combinational term, evaluated in the cycle before the edge that updates phase_q.
- len_cnt: on change, loads 1; otherwise increments, saturating at all-ones. At a change, len_cnt is the measured length of phase_q.
- Legal transitions: 00->01, 01->10, 10->00. Any other change is illegal.
- FSM UNSYNC: ignores lengths and order.
  - On a 10->00 change, go to SYNC.
  - The partial first phase is never length-checked.
- FSM SYNC: all errors below apply.
  - On a legal 10->00 change with no error in that cycle, go to LOCKED.
- FSM LOCKED: on each legal 10->00 change with no error, round_cnt += 1.
- Code 11 on phase_in: set err_code at that edge; next state UNSYNC. Applies in any state, including UNSYNC.
- In SYNC or LOCKED:
  - An illegal change sets err_order; next state UNSYNC.
  - A legal change with len_cnt outside [MINx,MAXx] for old phase x sets err_len; next state UNSYNC.
  - Multiple errors in one cycle set all applicable flags.
- last_len <= len_cnt on every change in SYNC/LOCKED, regardless of error.
- Enables at each edge:
  - If next state is LOCKED, {en_p2,en_p1,en_p0} <= one-hot(phase_in).
  - Otherwise all enables <= 0.
  - Latency: 1 cycle from phase_in to enable. Enables never assert outside LOCKED; at most one is high.
- locked: registered, equals (state==LOCKED).
- Sticky errors: cleared by clr_err=1 at an edge. If an error event and clr_err occur in the same cycle, the flag is set (event wins).
- Reset mid-operation: at the reset edge, all state and outputs return to reset values, regardless of FSM state or pending change.
- len_cnt saturation:
  - A phase held ≥ 2^LEN_W-1 cycles reports len=511 and fails MAXx.
  - The failure is reported when the change occurs, not while the phase is held.

Test Plan:
- Reset, then 3 clean rounds (00×101, 01×20, 10×80) -> SYNC after first 10->00; locked=1 after second; round_cnt=1 after third; one-hot enables track phase_in with 1-cycle latency; no errors.
- Locked, then phase 1 held 25 cycles -> at the 01->10 edge: err_len=1, last_len=25, locked=0, enables 0 the following cycle.
- Locked, then 00->10 directly -> err_order=1, FSM UNSYNC; later clean 10->00, full round -> relock; err_order stays 1 until clr_err pulse.
- Any state, phase_in=11 for 1 cycle -> err_code=1, enables 0, locked=0.
- clr_err=1 in the same cycle as a length violation -> err_len=1 afterward; clr_err alone next cycle -> err_len=0.
- rst=0 for 1 cycle mid-phase-2 while locked -> next cycle all outputs 0, round_cnt=0, FSM UNSYNC.
